// File: rtl/memory_interface_unit.sv
// MAR/MDR register pair plus a two-state handshake FSM that drives a simple
// req/ack memory port, with a bounded wait that flags a sticky timeout error.
module memory_interface_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              mem_start,
  input  logic              mem_write,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       BusMuxIn_MDR,
  output logic [31:0]       BusMuxIn_MAR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [0:0]  state;
  logic [31:0] mar;
  logic [31:0] mdr;
  logic [7:0]  count;
  logic        we;
  logic        done_q;
  logic        err_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      mar    <= '0;
      mdr    <= '0;
      count  <= '0;
      we     <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // A start drops same-cycle register loads so the transaction uses
          // the MAR/MDR values that were already present.
          if (mem_start) begin
            state <= WAIT;
            we    <= mem_write;
            err_q <= 1'b0;
            count <= '0;
          end else begin
            if (MARin) mar <= BusMuxOut;
            if (MDRin) mdr <= Read ? mem_rdata : BusMuxOut;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state  <= IDLE;
            we     <= 1'b0;
            done_q <= 1'b1;
            if (!we) mdr <= mem_rdata;
          end else if (count == LAST_COUNT) begin
            state  <= IDLE;
            we     <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == WAIT);
  assign mem_req      = busy;
  assign mem_we       = we;
  assign done         = done_q;
  assign err          = err_q;
  assign BusMuxIn_MAR = mar;
  assign BusMuxIn_MDR = mdr;
  assign mem_addr     = mar[ADDR_W-1:0];
  assign mem_wdata    = mdr;

endmodule

// File: tb/tb_memory_interface_unit.sv
// Directed-step bench for memory_interface_unit with immediate-assertion checks.
module tb_memory_interface_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read;
  logic        mem_start, mem_write, mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] BusMuxIn_MDR, BusMuxIn_MAR, mem_wdata;
  logic [8:0]  mem_addr;
  logic        mem_req, mem_we, busy, done, err;

  int errors = 0;
  int checks = 0;
  int n;

  memory_interface_unit #(.ADDR_W(9), .TIMEOUT(16)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin),
    .MDRin(MDRin), .Read(Read), .mem_start(mem_start), .mem_write(mem_write),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .BusMuxIn_MDR(BusMuxIn_MDR),
    .BusMuxIn_MAR(BusMuxIn_MAR), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0;
    mem_start = 0; mem_write = 0; mem_ack = 0; mem_rdata = '0;
    #3;
    chk("rst_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err}, 32'd0);
    chk("rst_mdr",  BusMuxIn_MDR, 32'd0);
    chk("rst_mar",  BusMuxIn_MAR, 32'd0);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    #9 clear = 1'b1;

    // Read with ack after 3 cycles
    BusMuxOut = 32'h0000_0055; MARin = 1;
    step(); MARin = 0;
    chk("rd_addr", {23'd0, mem_addr}, 32'h055);
    mem_start = 1; mem_write = 0;
    step(); mem_start = 0;
    chk("rd_busy1", {31'd0, busy}, 32'd1);
    chk("rd_req1",  {31'd0, mem_req}, 32'd1);
    chk("rd_we",    {31'd0, mem_we}, 32'd0);
    step(); chk("rd_busy2", {31'd0, busy}, 32'd1);
    chk("rd_done_early", {31'd0, done}, 32'd0);
    step(); chk("rd_busy3", {31'd0, busy}, 32'd1);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    step(); mem_ack = 0;
    chk("rd_busy_end", {31'd0, busy}, 32'd0);
    chk("rd_done", {31'd0, done}, 32'd1);
    chk("rd_mdr", BusMuxIn_MDR, 32'hDEAD_BEEF);
    chk("rd_err", {31'd0, err}, 32'd0);
    step(); chk("rd_done_pulse", {31'd0, done}, 32'd0);

    // Write transaction from bus-loaded MDR
    Read = 0; MDRin = 1; BusMuxOut = 32'h1234_5678;
    step(); MDRin = 0;
    chk("wr_mdr_load", BusMuxIn_MDR, 32'h1234_5678);
    mem_start = 1; mem_write = 1;
    step(); mem_start = 0; mem_write = 0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_we", {31'd0, mem_we}, 32'd1);
      chk("wr_wdata", mem_wdata, 32'h1234_5678);
      if (i < 2) step();
    end
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    step(); mem_ack = 0;
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_mdr_hold", BusMuxIn_MDR, 32'h1234_5678);
    chk("wr_we_drop", {31'd0, mem_we}, 32'd0);

    // Timeout with no ack
    step();
    mem_start = 1; mem_write = 0;
    step(); mem_start = 0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 32'd16);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_mdr", BusMuxIn_MDR, 32'h1234_5678);
    step();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    mem_start = 1; mem_write = 0;
    step(); mem_start = 0;
    chk("to_err_clr", {31'd0, err}, 32'd0);
    mem_ack = 1; mem_rdata = 32'hA5A5_A5A5;
    step(); mem_ack = 0;
    chk("to_next_mdr", BusMuxIn_MDR, 32'hA5A5_A5A5);

    // Start beats MARin; loads ignored during WAIT
    BusMuxOut = 32'h99; MARin = 1; mem_start = 1; mem_write = 1;
    step(); MARin = 0; mem_start = 0; mem_write = 0;
    chk("pr_addr", {23'd0, mem_addr}, 32'h055);
    chk("pr_busy", {31'd0, busy}, 32'd1);
    MARin = 1; MDRin = 1; Read = 0; BusMuxOut = 32'h77;
    step(); MARin = 0; MDRin = 0;
    chk("pr_wait_addr", {23'd0, mem_addr}, 32'h055);
    chk("pr_wait_mdr", BusMuxIn_MDR, 32'hA5A5_A5A5);
    mem_ack = 1;
    step(); mem_ack = 0;
    chk("pr_done", {31'd0, done}, 32'd1);
    chk("pr_mar", BusMuxIn_MAR, 32'h55);
    chk("pr_mdr", BusMuxIn_MDR, 32'hA5A5_A5A5);

    // Ack in IDLE ignored
    mem_ack = 1; mem_rdata = 32'h1111_1111;
    step(); mem_ack = 0;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_done", {31'd0, done}, 32'd0);
    chk("idle_ack_mdr", BusMuxIn_MDR, 32'hA5A5_A5A5);

    // Async clear mid-transaction
    mem_start = 1; mem_write = 0;
    step(); mem_start = 0;
    step();
    chk("clr_pre_busy", {31'd0, busy}, 32'd1);
    #2 clear = 1'b0;
    #1;
    chk("clr_req", {31'd0, mem_req}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_mdr", BusMuxIn_MDR, 32'd0);
    chk("clr_mar", BusMuxIn_MAR, 32'd0);
    mem_ack = 1; mem_rdata = 32'h2222_2222;
    step();
    chk("clr_no_done", {31'd0, done}, 32'd0);
    @(negedge clock); clear = 1'b1; mem_ack = 0;
    step();
    chk("clr_after_done", {31'd0, done}, 32'd0);
    chk("clr_after_busy", {31'd0, busy}, 32'd0);

    // Address truncation
    BusMuxOut = 32'hFFFF_FE23; MARin = 1;
    step(); MARin = 0;
    chk("tr_mar", BusMuxIn_MAR, 32'hFFFF_FE23);
    chk("tr_addr", {23'd0, mem_addr}, 32'h023);

    // Ack on the final (16th) WAIT edge wins over timeout
    mem_start = 1; mem_write = 0;
    step(); mem_start = 0;
    for (int i = 0; i < 15; i++) step();
    chk("edge_busy", {31'd0, busy}, 32'd1);
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    step(); mem_ack = 0;
    chk("edge_done", {31'd0, done}, 32'd1);
    chk("edge_err", {31'd0, err}, 32'd0);
    chk("edge_mdr", BusMuxIn_MDR, 32'hCAFE_F00D);
    chk("edge_busy_end", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
